// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler: function codes, FSM states, CC reset value.
package alu_pkg;

    localparam logic [1:0] FN_ADD = 2'd0;
    localparam logic [1:0] FN_SUB = 2'd1;
    localparam logic [1:0] FN_AND = 2'd2;
    localparam logic [1:0] FN_XOR = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    // {ZF, SF, OF} after reset
    localparam logic [2:0] CC_RST = 3'b100;

endpackage

// File: rtl/alu_sched_if.sv
// Request/response bundle between the two requesters, the consumer and the scheduler.
interface alu_sched_if #(
    parameter int unsigned W = 64
);
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req_fn0;
    logic [1:0]   req_fn1;
    logic [W-1:0] req_a0;
    logic [W-1:0] req_b0;
    logic [W-1:0] req_a1;
    logic [W-1:0] req_b1;
    logic [1:0]   req_setcc;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_ovf;
    logic         cc_zf;
    logic         cc_sf;
    logic         cc_of;

    modport master (
        output req_valid, req_fn0, req_fn1, req_a0, req_b0, req_a1, req_b1, req_setcc,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf, cc_zf, cc_sf, cc_of
    );

    modport slave (
        input  req_valid, req_fn0, req_fn1, req_a0, req_b0, req_a1, req_b1, req_setcc,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf, cc_zf, cc_sf, cc_of
    );
endinterface

// File: rtl/ALU.sv
// Combinational 64-bit ALU: {c1,c0} = 00 add, 01 sub, 10 and, 11 xor.
module ALU #(
    parameter int unsigned W = 64
) (
    input  logic         c0,
    input  logic         c1,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] output_alu,
    output logic         bit_overflow
);
    logic [W-1:0] b_eff;
    logic [W-1:0] sum;
    logic         carry_msb_in;
    logic         carry_out;

    // Adder split at the MSB so the carry into and out of it are both visible
    always_comb begin
        b_eff = c0 ? ~b : b;
        {carry_msb_in, sum[W-2:0]} = {1'b0, a[W-2:0]} + {1'b0, b_eff[W-2:0]}
                                     + {{(W-1){1'b0}}, c0};
        sum[W-1]  = a[W-1] ^ b_eff[W-1] ^ carry_msb_in;
        carry_out = (a[W-1] & b_eff[W-1]) | (carry_msb_in & (a[W-1] ^ b_eff[W-1]));
        output_alu   = sum;
        bit_overflow = 1'b0;
        unique case ({c1, c0})
            2'b00, 2'b01: bit_overflow = carry_out ^ carry_msb_in;
            2'b10:        output_alu   = a & b;
            2'b11:        output_alu   = a ^ b;
            default:      output_alu   = sum;
        endcase
    end
endmodule

// File: rtl/alu_sched.sv
// Round-robin two-requester scheduler around one shared ALU; owns the CC register.
module alu_sched
    import alu_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input logic       clk,
    input logic       rst,
    alu_sched_if.slave bus
);
    state_e       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic [1:0]   fn_q, fn_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic         setcc_q, setcc_d;
    logic         id_q, id_d;
    logic [W-1:0] result_q, result_d;
    logic         ovf_q, ovf_d;
    cc_t          cc_q, cc_d;

    logic [1:0]   ready;
    logic         grant;
    logic [W-1:0] alu_y;
    logic         alu_ovf;

    ALU #(.W(W)) u_alu (
        .c0          (fn_q[0]),
        .c1          (fn_q[1]),
        .a           (a_q),
        .b           (b_q),
        .output_alu  (alu_y),
        .bit_overflow(alu_ovf)
    );

    // Arbitration: one-hot ready in IDLE only; ties go to the requester not granted last
    always_comb begin
        ready = 2'b00;
        if (state_q == StIdle && !rst) begin
            unique case (bus.req_valid)
                2'b01:   ready = 2'b01;
                2'b10:   ready = 2'b10;
                2'b11:   ready = last_grant_q ? 2'b01 : 2'b10;
                default: ready = 2'b00;
            endcase
        end
        grant = ready[1];
    end

    // Next-state: latch on accept, register ALU output and CC at EXEC->RESP
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        fn_d         = fn_q;
        a_d          = a_q;
        b_d          = b_q;
        setcc_d      = setcc_q;
        id_d         = id_q;
        result_d     = result_q;
        ovf_d        = ovf_q;
        cc_d         = cc_q;
        unique case (state_q)
            StIdle: begin
                if (|ready) begin
                    state_d      = StExec;
                    last_grant_d = grant;
                    id_d         = grant;
                    fn_d         = grant ? bus.req_fn1 : bus.req_fn0;
                    a_d          = grant ? bus.req_a1 : bus.req_a0;
                    b_d          = grant ? bus.req_b1 : bus.req_b0;
                    setcc_d      = bus.req_setcc[grant];
                end
            end
            StExec: begin
                state_d  = StResp;
                result_d = alu_y;
                ovf_d    = alu_ovf;
                if (setcc_q) begin
                    cc_d.zf = (alu_y == '0);
                    cc_d.sf = alu_y[W-1];
                    cc_d.of = alu_ovf;
                end
            end
            StResp: begin
                if (bus.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            fn_q         <= FN_ADD;
            a_q          <= '0;
            b_q          <= '0;
            setcc_q      <= 1'b0;
            id_q         <= 1'b0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            cc_q         <= cc_t'(CC_RST);
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            fn_q         <= fn_d;
            a_q          <= a_d;
            b_q          <= b_d;
            setcc_q      <= setcc_d;
            id_q         <= id_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            cc_q         <= cc_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.rsp_valid  = (state_q == StResp);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_ovf    = ovf_q;
    assign bus.cc_zf      = cc_q.zf;
    assign bus.cc_sf      = cc_q.sf;
    assign bus.cc_of      = cc_q.of;
endmodule
